// File: rtl/sync_fifo_pkg.sv
// Shared constants and types for the sync_fifo write-side sender.
package sync_fifo_pkg;

  localparam int          SYNC_FIFO_DEPTH = 4;
  localparam logic [15:0] COAL_MAX        = 16'hFFFF;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    GAP  = 1'b1
  } sender_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == COAL_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_sender_if.sv
// Status-bus / FIFO-write bundle between a status source and the sender.
interface sync_fifo_sender_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] data_in;
  logic             force_send;
  logic             write_en;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic [15:0]      coalesce_count;

  // master: the sender, which owns the FIFO write strobe
  modport master (
    input  data_in, force_send,
    output write_en, data_out, busy, coalesce_count
  );

  modport slave (
    output data_in, force_send,
    input  write_en, data_out, busy, coalesce_count
  );
endinterface

// File: rtl/sync_fifo_credit.sv
// Credit pacing: one credit returns every REFILL_CYCLES clocks, capped at DEPTH.
module sync_fifo_credit
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH         = SYNC_FIFO_DEPTH,
  parameter int REFILL_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic take,
  output logic avail
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;

  logic [RW-1:0] refill_q, refill_d;
  logic [CW-1:0] credits_q, credits_d;
  logic          wrap;

  always_comb begin
    wrap      = (refill_q == RW'(REFILL_CYCLES - 1));
    refill_d  = wrap ? '0 : refill_q + RW'(1);
    credits_d = credits_q;
    // take and refill on the same edge cancel out
    if (wrap && !take && (credits_q != CW'(DEPTH)))
      credits_d = credits_q + CW'(1);
    else if (take && !wrap)
      credits_d = credits_q - CW'(1);
  end

  assign avail = (credits_q != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      refill_q  <= '0;
      credits_q <= CW'(DEPTH);
    end else begin
      refill_q  <= refill_d;
      credits_q <= credits_d;
    end
  end

endmodule

// File: rtl/sync_fifo_sender.sv
// Change-detecting, credit-paced writer into a 4-entry sync_fifo with no full flag.
module sync_fifo_sender
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH         = 2,
  parameter int DEPTH         = SYNC_FIFO_DEPTH,
  parameter int REFILL_CYCLES = 16,
  parameter int GAP_CYCLES    = 1
) (
  input logic               clk,
  input logic               reset_n,
  sync_fifo_sender_if.master bus
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  sender_state_t    state_q, state_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [WIDTH-1:0] shadow_q, shadow_d, pval_q, pval_d, dout_q, dout_d;
  logic             pend_q, pend_d, we_q, we_d, busy_q, busy_d;
  logic [15:0]      coal_q, coal_d;
  logic             cap, send, avail;

  sync_fifo_credit #(
    .DEPTH         (DEPTH),
    .REFILL_CYCLES (REFILL_CYCLES)
  ) u_credit (
    .clk     (clk),
    .reset_n (reset_n),
    .take    (send),
    .avail   (avail)
  );

  always_comb begin
    cap  = (bus.data_in != shadow_q) || bus.force_send;
    send = (state_q == IDLE) && pend_q && avail;

    shadow_d = cap ? bus.data_in : shadow_q;
    pval_d   = cap ? bus.data_in : pval_q;
    pend_d   = cap ? 1'b1 : (send ? 1'b0 : pend_q);
    // a capture landing on the send edge replaces a consumed value, not a live one
    coal_d   = (cap && pend_q && !send) ? sat_inc16(coal_q) : coal_q;

    we_d   = send;
    dout_d = send ? pval_q : dout_q;

    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: if (send) begin
        state_d = GAP;
        gap_d   = GW'(GAP_CYCLES - 1);
      end
      GAP: if (gap_q == '0) state_d = IDLE;
           else             gap_d   = gap_q - GW'(1);
      default: state_d = IDLE;
    endcase

    busy_d = pend_d || (state_d == GAP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      gap_q    <= '0;
      shadow_q <= '0;
      pval_q   <= '0;
      pend_q   <= 1'b0;
      coal_q   <= '0;
      we_q     <= 1'b0;
      dout_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      shadow_q <= shadow_d;
      pval_q   <= pval_d;
      pend_q   <= pend_d;
      coal_q   <= coal_d;
      we_q     <= we_d;
      dout_q   <= dout_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.write_en       = we_q;
  assign bus.data_out       = dout_q;
  assign bus.busy           = busy_q;
  assign bus.coalesce_count = coal_q;

endmodule
